line_buf: RTL and testbench
===========================

Name: line_buf

Overview:
- Consumer end of the keypad event interface: accepts single-cycle ascii/cursor/backspace enable pulses and edits a one-line character buffer.
- Tracks cursor and line length, and exposes a combinational read port so display logic can scan the buffer.
- On a "down" (enter) event, the block commits the line and transmits it, one byte per handshake, over a valid/ready stream. It then clears the buffer.

Parameters:
DEPTH, 16, number of character slots in the line (>=2)
CW, 5, width of cursor/length/read-address fields; must satisfy 2**CW > DEPTH

Ports:
clk  input  1  clock, all state on rising edge
i_arst_n  input  1  asynchronous active-low reset
i_ascii_en  input  1  one-cycle pulse: i_ascii is a new character
i_ascii  input  8  character code, sampled when i_ascii_en=1
i_backspace_en  input  1  one-cycle pulse: delete char left of cursor
i_right_en  input  1  one-cycle pulse: cursor right
i_left_en  input  1  one-cycle pulse: cursor left
i_down_en  input  1  one-cycle pulse: commit and transmit line
i_rd_addr  input  CW  display read address
o_rd_data  output  8  buf[i_rd_addr]; 8'h20 when i_rd_addr>=DEPTH (combinational)
o_cursor  output  CW  cursor position, 0..DEPTH
o_len  output  CW  line length, 0..DEPTH
o_full  output  1  o_len==DEPTH
o_busy  output  1  1 while in SEND state
o_tx_data  output  8  stream byte
o_tx_valid  output  1  stream valid
o_tx_last  output  1  qualifies final byte of line
i_tx_ready  input  1  stream ready

Behaviour:
- Reset (async assert, sync release):
  - All buf entries = 8'h20.
  - cursor=0, len=0, state=EDIT.
  - o_tx_valid=0, o_tx_last=0, o_tx_data=8'h00, o_busy=0.
- States: EDIT, SEND.
- EDIT state: at most one event is accepted per cycle. Priority is ascii > backspace > right > left > down; lower-priority pulses in the same cycle are dropped.
  - ascii: if cursor<DEPTH, then buf[cursor]<=i_ascii, cursor<=cursor+1, len<=max(len,cursor+1). Overwrite mode. If cursor==DEPTH, the event is ignored.
  - backspace: if cursor>0, then buf[k]<=buf[k+1] for k=cursor-1..DEPTH-2, buf[DEPTH-1]<=8'h20, cursor<=cursor-1, len<=len-1, all in one cycle. If cursor==0, the event is ignored.
  - right: if cursor<len, cursor<=cursor+1; else hold.
  - left: if cursor>0, cursor<=cursor-1; else hold.
  - down: if len==0, ignored. Otherwise state<=SEND, rd index<=0, o_busy<=1.
  - o_cursor, o_len and the buffer update on the clock edge after the pulse (1-cycle latency).
- SEND state: all edit inputs are ignored, including pulses arriving during SEND (they are not queued).
  - o_tx_valid=1, o_tx_data=buf[idx], o_tx_last=(idx==len-1). These are registered and stable while valid&&!ready.
  - First valid appears one cycle after the down pulse.
  - Transfer happens on a cycle with o_tx_valid&&i_tx_ready. After a non-last transfer, idx<=idx+1 and the next byte is presented the following cycle; back-to-back transfers sustain 1 byte/cycle.
  - After the last transfer, on the next edge: o_tx_valid=0, o_tx_last=0, all buf entries=8'h20, cursor=0, len=0, state=EDIT, o_busy=0.
- Read port: purely combinational and valid in both states. Contents seen during SEND are the frozen line.
- Reset asserted mid-SEND: transfer is aborted immediately, valid drops asynchronously, and the buffer returns to reset values. No o_tx_last is produced.
- Width rules:
  - cursor, len and idx are CW bits, unsigned.
  - No wrap: cursor saturates at 0 and DEPTH, len saturates at DEPTH.
  - Invariant cursor<=len holds at all times.

Test Plan:
- Reset, pulse ascii 'A'(8'h41), 'B', 'C' -> o_len=3, o_cursor=3, rd addr 1 = 8'h42, rd addr 3 = 8'h20.
- After "ABC": left, left, backspace -> buffer "BC", o_cursor=0, o_len=2; a further backspace is ignored; right x3 -> o_cursor saturates at 2.
- Write 17 chars with DEPTH=16 -> o_full=1, o_len=16, o_cursor=16, and the 17th char is dropped (buf[15] = 16th char).
- "HI" then down, i_tx_ready held high -> valid on cycle+1 with 8'h48 last=0, next cycle 8'h49 last=1; then o_busy=0, o_len=0, buf all 8'h20.
- "HI" then down with i_tx_ready toggling 0,1,0,0,1 -> data held during stalls, exactly 2 transfers; ascii/left pulses injected mid-SEND leave the buffer unchanged.
- Simultaneous ascii 'X' + left + down pulses in one cycle -> only 'X' written (cursor+1), no SEND; down on an empty line -> no valid, state stays EDIT; reset pulse mid-SEND -> o_tx_valid=0 at once, o_len=0.

Source files
------------

// File: rtl/line_buf.sv
// line_buf: one-line character editor that streams the committed line out over valid/ready
module line_buf #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          i_arst_n,
    input  logic          i_ascii_en,
    input  logic [7:0]    i_ascii,
    input  logic          i_backspace_en,
    input  logic          i_right_en,
    input  logic          i_left_en,
    input  logic          i_down_en,
    input  logic [CW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic [CW-1:0] o_cursor,
    output logic [CW-1:0] o_len,
    output logic          o_full,
    output logic          o_busy,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    output logic          o_tx_last,
    input  logic          i_tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEP = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic {EDIT, SEND} state_t;

    state_t        state, state_d;
    logic [7:0]    line_q [DEPTH];
    logic [7:0]    bs_line [DEPTH];
    logic [CW-1:0] cursor, len, idx;
    logic [CW-1:0] ncur, pcur, nidx;
    logic          sel_ascii, sel_bs, sel_right, sel_left, sel_down;
    logic          go, xfer, done;

    assign ncur = cursor + ONE;
    assign pcur = cursor - ONE;
    assign nidx = idx + ONE;

    // event decode with fixed priority, next-state selection and backspace shift image
    always_comb begin
        sel_ascii = (state == EDIT) && i_ascii_en;
        sel_bs    = (state == EDIT) && !i_ascii_en && i_backspace_en;
        sel_right = (state == EDIT) && !i_ascii_en && !i_backspace_en && i_right_en;
        sel_left  = (state == EDIT) && !i_ascii_en && !i_backspace_en && !i_right_en && i_left_en;
        sel_down  = (state == EDIT) && !i_ascii_en && !i_backspace_en && !i_right_en && !i_left_en && i_down_en;
        go        = sel_down && (len != '0);
        xfer      = o_tx_valid && i_tx_ready;
        done      = xfer && o_tx_last;
        state_d   = go ? SEND : done ? EDIT : state;
        for (int k = 0; k < DEPTH; k++) begin
            bs_line[k] = (CW'(k) >= pcur) ? ((k == DEPTH - 1) ? 8'h20 : line_q[(k + 1) % DEPTH]) : line_q[k];
        end
    end

    // state register
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) state <= EDIT;
        else           state <= state_d;
    end

    // line buffer, cursor and length editing; cleared once the line has been sent
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n || done) begin
            for (int k = 0; k < DEPTH; k++) line_q[k] <= 8'h20;
            cursor <= '0;
            len    <= '0;
        end else if (sel_ascii && cursor != DEP) begin
            line_q[cursor[AW-1:0]] <= i_ascii;
            cursor <= ncur;
            len    <= (ncur > len) ? ncur : len;
        end else if (sel_bs && cursor != '0) begin
            line_q <= bs_line;
            cursor <= pcur;
            len    <= len - ONE;
        end else if (sel_right && cursor < len) begin
            cursor <= ncur;
        end else if (sel_left && cursor != '0) begin
            cursor <= pcur;
        end
    end

    // registered transmit stream; holds while stalled, advances one byte per transfer
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_tx_data  <= 8'h00;
            idx        <= '0;
        end else if (go) begin
            o_tx_valid <= 1'b1;
            o_tx_last  <= (len == ONE);
            o_tx_data  <= line_q[0];
            idx        <= '0;
        end else if (done) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_tx_data  <= 8'h00;
            idx        <= '0;
        end else if (xfer) begin
            o_tx_last  <= (nidx == len - ONE);
            o_tx_data  <= line_q[nidx[AW-1:0]];
            idx        <= nidx;
        end
    end

    assign o_rd_data = (i_rd_addr < DEP) ? line_q[i_rd_addr[AW-1:0]] : 8'h20;
    assign o_cursor  = cursor;
    assign o_len     = len;
    assign o_full    = (len == DEP);
    assign o_busy    = (state == SEND);

endmodule

// File: tb/tb_line_buf.sv
// tb_line_buf: directed self-checking bench for line_buf
module tb_line_buf;
    logic       clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic       i_ascii_en = 1'b0;
    logic [7:0] i_ascii = 8'h00;
    logic       i_backspace_en = 1'b0;
    logic       i_right_en = 1'b0;
    logic       i_left_en = 1'b0;
    logic       i_down_en = 1'b0;
    logic [4:0] i_rd_addr = 5'd0;
    logic [7:0] o_rd_data;
    logic [4:0] o_cursor;
    logic [4:0] o_len;
    logic       o_full;
    logic       o_busy;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_tx_last;
    logic       i_tx_ready = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         xfers = 0;
    int         x0;

    line_buf #(.DEPTH(16), .CW(5)) dut (
        .clk(clk), .i_arst_n(i_arst_n),
        .i_ascii_en(i_ascii_en), .i_ascii(i_ascii),
        .i_backspace_en(i_backspace_en), .i_right_en(i_right_en),
        .i_left_en(i_left_en), .i_down_en(i_down_en),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_cursor(o_cursor), .o_len(o_len), .o_full(o_full), .o_busy(o_busy),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last),
        .i_tx_ready(i_tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_tx_valid && i_tx_ready) xfers <= xfers + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        i_rd_addr = a;
        #1;
        chk(tag, o_rd_data, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic a, input logic [7:0] c, input logic bs, input logic r, input logic l, input logic d);
        i_ascii_en = a; i_ascii = c; i_backspace_en = bs; i_right_en = r; i_left_en = l; i_down_en = d;
        step();
        i_ascii_en = 0; i_backspace_en = 0; i_right_en = 0; i_left_en = 0; i_down_en = 0;
    endtask

    task automatic key(input logic [7:0] c);
        ev(1, c, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        i_arst_n = 1'b0;
        step();
        i_arst_n = 1'b1;
    endtask

    initial begin
        i_tx_ready = 0;
        step();
        step();
        chk("rst_valid", o_tx_valid, 0);
        chk("rst_last", o_tx_last, 0);
        chk("rst_data", o_tx_data, 8'h00);
        chk("rst_busy", o_busy, 0);
        chk("rst_len", o_len, 0);
        chk("rst_cursor", o_cursor, 0);
        rd("rst_rd0", 5'd0, 8'h20);
        i_arst_n = 1'b1;
        step();
        key(8'h41); key(8'h42); key(8'h43);
        chk("abc_len", o_len, 3);
        chk("abc_cursor", o_cursor, 3);
        rd("abc_rd0", 5'd0, 8'h41);
        rd("abc_rd1", 5'd1, 8'h42);
        rd("abc_rd3", 5'd3, 8'h20);
        rd("abc_rd20", 5'd20, 8'h20);
        ev(0, 0, 0, 0, 1, 0);
        ev(0, 0, 0, 0, 1, 0);
        chk("left2_cursor", o_cursor, 1);
        ev(0, 0, 1, 0, 0, 0);
        chk("bs_cursor", o_cursor, 0);
        chk("bs_len", o_len, 2);
        rd("bs_rd0", 5'd0, 8'h42);
        rd("bs_rd1", 5'd1, 8'h43);
        rd("bs_rd2", 5'd2, 8'h20);
        ev(0, 0, 1, 0, 0, 0);
        chk("bs0_len", o_len, 2);
        chk("bs0_cursor", o_cursor, 0);
        rd("bs0_rd0", 5'd0, 8'h42);
        ev(0, 0, 0, 1, 0, 0); ev(0, 0, 0, 1, 0, 0); ev(0, 0, 0, 1, 0, 0);
        chk("right_sat", o_cursor, 2);
        ev(0, 0, 0, 0, 1, 0);
        ev(0, 0, 0, 0, 1, 0);
        ev(0, 0, 0, 0, 1, 0);
        chk("left_sat", o_cursor, 0);

        do_reset();
        for (int i = 0; i < 15; i++) key(8'h61 + 8'(i));
        chk("full15", o_full, 0);
        key(8'h70);
        key(8'h71);
        chk("full16", o_full, 1);
        chk("full_len", o_len, 16);
        chk("full_cursor", o_cursor, 16);
        rd("full_rd15", 5'd15, 8'h70);
        rd("full_rd0", 5'd0, 8'h61);

        do_reset();
        key(8'h48); key(8'h49);
        i_tx_ready = 1;
        x0 = xfers;
        ev(0, 0, 0, 0, 0, 1);
        chk("s1_valid", o_tx_valid, 1);
        chk("s1_data0", o_tx_data, 8'h48);
        chk("s1_last0", o_tx_last, 0);
        chk("s1_busy", o_busy, 1);
        step();
        chk("s1_valid1", o_tx_valid, 1);
        chk("s1_data1", o_tx_data, 8'h49);
        chk("s1_last1", o_tx_last, 1);
        step();
        chk("s1_end_valid", o_tx_valid, 0);
        chk("s1_end_last", o_tx_last, 0);
        chk("s1_end_busy", o_busy, 0);
        chk("s1_end_len", o_len, 0);
        chk("s1_end_cursor", o_cursor, 0);
        chk("s1_xfers", xfers - x0, 2);
        rd("s1_end_rd0", 5'd0, 8'h20);
        rd("s1_end_rd1", 5'd1, 8'h20);

        i_tx_ready = 0;
        key(8'h48); key(8'h49);
        x0 = xfers;
        ev(0, 0, 0, 0, 0, 1);
        chk("s2_valid", o_tx_valid, 1);
        chk("s2_data0", o_tx_data, 8'h48);
        ev(1, 8'h5a, 0, 0, 1, 0);
        chk("s2_stall_data", o_tx_data, 8'h48);
        chk("s2_stall_valid", o_tx_valid, 1);
        chk("s2_frozen_len", o_len, 2);
        chk("s2_frozen_cur", o_cursor, 2);
        rd("s2_frozen_rd0", 5'd0, 8'h48);
        rd("s2_frozen_rd1", 5'd1, 8'h49);
        i_tx_ready = 1;
        step();
        chk("s2_data1", o_tx_data, 8'h49);
        chk("s2_last1", o_tx_last, 1);
        i_tx_ready = 0;
        step();
        chk("s2_hold_data", o_tx_data, 8'h49);
        chk("s2_hold_last", o_tx_last, 1);
        ev(0, 0, 0, 0, 1, 0);
        chk("s2_hold2_valid", o_tx_valid, 1);
        chk("s2_hold2_cur", o_cursor, 2);
        i_tx_ready = 1;
        step();
        i_tx_ready = 0;
        chk("s2_end_valid", o_tx_valid, 0);
        chk("s2_end_busy", o_busy, 0);
        chk("s2_end_len", o_len, 0);
        chk("s2_xfers", xfers - x0, 2);

        ev(1, 8'h58, 0, 0, 1, 1);
        chk("sim_len", o_len, 1);
        chk("sim_cursor", o_cursor, 1);
        chk("sim_busy", o_busy, 0);
        chk("sim_valid", o_tx_valid, 0);
        rd("sim_rd0", 5'd0, 8'h58);

        do_reset();
        ev(0, 0, 0, 0, 0, 1);
        chk("empty_valid", o_tx_valid, 0);
        chk("empty_busy", o_busy, 0);

        key(8'h51);
        ev(0, 0, 0, 0, 0, 1);
        chk("mid_valid", o_tx_valid, 1);
        chk("mid_last", o_tx_last, 1);
        #2;
        i_arst_n = 1'b0;
        #1;
        chk("arst_valid", o_tx_valid, 0);
        chk("arst_last", o_tx_last, 0);
        chk("arst_len", o_len, 0);
        chk("arst_busy", o_busy, 0);
        rd("arst_rd0", 5'd0, 8'h20);
        step();
        i_arst_n = 1'b1;
        step();
        chk("post_valid", o_tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
